// File: rtl/arf_param.sv
// Parametrised address register file: NREG x WIDTH registers, multi-select clear/load/inc/dec,
// two registered write-through read ports, sticky wrap flags. Define ARF_SATURATE_EN to saturate inc/dec.
module arf_param #(
  parameter int              WIDTH   = 8,
  parameter int              NREG    = 4,
  parameter int              SEL_W   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       fun_sel,
  input  logic [NREG-1:0]  r_sel,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0] out_a_sel,
  input  logic [SEL_W-1:0] out_b_sel,
  input  logic [NREG-1:0]  flag_clr,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [NREG-1:0]  wrap_flag
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [NREG-1:0]  wrap_q, wrap_d, wrap_set;

  always_comb begin
    wrap_set = '0;
    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
      if (en && r_sel[k]) begin
        unique case (fun_sel)
          2'b00: regs_d[k] = '0;
          2'b01: regs_d[k] = i_data;
          2'b10: begin
            if (regs_q[k] == ALL_ONES) wrap_set[k] = 1'b1;
`ifdef ARF_SATURATE_EN
            regs_d[k] = (regs_q[k] == ALL_ONES) ? ALL_ONES : regs_q[k] + ONE;
`else
            regs_d[k] = regs_q[k] + ONE;
`endif
          end
          2'b11: begin
            if (regs_q[k] == '0) wrap_set[k] = 1'b1;
`ifdef ARF_SATURATE_EN
            regs_d[k] = (regs_q[k] == '0) ? '0 : regs_q[k] - ONE;
`else
            regs_d[k] = regs_q[k] - ONE;
`endif
          end
          default: regs_d[k] = regs_q[k];
        endcase
      end
    end

    // Set beats clear so a wrap on the same edge as its acknowledge is never lost.
    wrap_d = (wrap_q & ~flag_clr) | wrap_set;

    // Read ports see the post-update value; out-of-range selects read as zero.
    out_a_d = '0;
    out_b_d = '0;
    for (int k = 0; k < NREG; k++) begin
      if (out_a_sel == SEL_W'(k)) out_a_d = regs_d[k];
      if (out_b_sel == SEL_W'(k)) out_b_d = regs_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= RST_VAL;
      out_a_q <= RST_VAL;
      out_b_q <= RST_VAL;
      wrap_q  <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_arf_param.sv
// Scoreboard bench for arf_param: default 4x8 instance plus a 6x16 instance for parameter coverage.
module tb_arf_param;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   fun_sel;
  logic [N-1:0] r_sel;
  logic [W-1:0] i_data;
  logic [S-1:0] a_sel, b_sel;
  logic [N-1:0] flag_clr;
  logic [W-1:0] out_a, out_b;
  logic [N-1:0] wrap_flag;

  logic         p_en;
  logic [1:0]   p_fun;
  logic [5:0]   p_rsel;
  logic [15:0]  p_data;
  logic [2:0]   p_asel, p_bsel;
  logic [5:0]   p_fclr;
  logic [15:0]  p_out_a, p_out_b;
  logic [5:0]   p_wrap;

  always #5 clk = ~clk;

  arf_param dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fun_sel(fun_sel), .r_sel(r_sel),
    .i_data(i_data), .out_a_sel(a_sel), .out_b_sel(b_sel), .flag_clr(flag_clr),
    .out_a(out_a), .out_b(out_b), .wrap_flag(wrap_flag)
  );

  arf_param #(.WIDTH(16), .NREG(6), .SEL_W(3), .RST_VAL(16'h0000)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(p_en), .fun_sel(p_fun), .r_sel(p_rsel),
    .i_data(p_data), .out_a_sel(p_asel), .out_b_sel(p_bsel), .flag_clr(p_fclr),
    .out_a(p_out_a), .out_b(p_out_b), .wrap_flag(p_wrap)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] f;
  } snap_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  f;
  } snap6_t;

  snap_t  exp_q[$], obs_q[$];
  snap6_t exp6_q[$], obs6_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_reg [N];
  logic [N-1:0] m_flag;

  function automatic logic [W-1:0] m_read(input logic [S-1:0] s);
    if (int'(s) < N) return m_reg[s];
    return '0;
  endfunction

  // Reference behaviour of one clock edge with reset released.
  task automatic m_step(input logic e, input logic [1:0] f, input logic [N-1:0] rs,
                        input logic [W-1:0] d, input logic [N-1:0] fc);
    logic [N-1:0] set;
    set = '0;
    for (int k = 0; k < N; k++) begin
      if (e && rs[k]) begin
        case (f)
          2'b00: m_reg[k] = 8'h00;
          2'b01: m_reg[k] = d;
          2'b10: begin
            if (m_reg[k] == 8'hFF) begin
              set[k] = 1'b1;
`ifdef ARF_SATURATE_EN
              m_reg[k] = 8'hFF;
`else
              m_reg[k] = 8'h00;
`endif
            end else m_reg[k] = m_reg[k] + 8'h01;
          end
          default: begin
            if (m_reg[k] == 8'h00) begin
              set[k] = 1'b1;
`ifdef ARF_SATURATE_EN
              m_reg[k] = 8'h00;
`else
              m_reg[k] = 8'hFF;
`endif
            end else m_reg[k] = m_reg[k] - 8'h01;
          end
        endcase
      end
    end
    m_flag = (m_flag & ~fc) | set;
  endtask

  task automatic m_reset();
    for (int k = 0; k < N; k++) m_reg[k] = 8'h00;
    m_flag = '0;
  endtask

  // Drive one cycle, push the model's expectation, then capture what the DUT produced.
  task automatic cyc(input logic e, input logic [1:0] f, input logic [N-1:0] rs,
                     input logic [W-1:0] d, input logic [S-1:0] as, input logic [S-1:0] bs,
                     input logic [N-1:0] fc);
    @(negedge clk);
    en = e; fun_sel = f; r_sel = rs; i_data = d; a_sel = as; b_sel = bs; flag_clr = fc;
    m_step(e, f, rs, d, fc);
    exp_q.push_back('{a: m_read(as), b: m_read(bs), f: m_flag});
    @(posedge clk);
    #1;
    obs_q.push_back('{a: out_a, b: out_b, f: wrap_flag});
  endtask

  task automatic test_reset();
    snap_t e, o;
    cyc(1, 2'b01, 4'b1111, 8'h3C, 0, 1, 0);
    cyc(1, 2'b01, 4'b0001, 8'hFF, 0, 2, 0);
    cyc(1, 2'b10, 4'b0001, 8'h00, 0, 3, 0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({out_a, out_b, wrap_flag} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got a=%h b=%h f=%b, need all zero", out_a, out_b, wrap_flag);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_a, out_b, wrap_flag} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_held: got a=%h b=%h f=%b, need all zero", out_a, out_b, wrap_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 2'b01, 4'b1111, 8'h5A, 0, 3, 0);
    cyc(0, 2'b00, 4'b0000, 8'h00, 1, 2, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL reset_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_multi_select();
    snap_t e, o;
    cyc(1, 2'b01, 4'b1111, 8'h10, 0, 2, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b10, 4'b1000, 8'h00, 3, 0, 0);
    cyc(1, 2'b11, 4'b0010, 8'h00, 3, 1, 0);
    n_cmp++;
    if (out_a !== 8'h13 || out_b !== 8'h0F) begin
      n_bad++;
      $display("[TB] FAIL multi_pc_sp: got %h/%h, need 13/0f", out_a, out_b);
    end
    cyc(0, 2'b00, 4'b1111, 8'h00, 0, 2, 0);
    n_cmp++;
    if (out_a !== 8'h10 || out_b !== 8'h10) begin
      n_bad++;
      $display("[TB] FAIL multi_ar_pcpast: got %h/%h, need 10/10", out_a, out_b);
    end
    cyc(1, 2'b10, 4'b0000, 8'h00, 3, 3, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL multi_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    logic [W-1:0] sp_exp, ar_exp;
`ifdef ARF_SATURATE_EN
    sp_exp = 8'hFF; ar_exp = 8'h00;
`else
    sp_exp = 8'h00; ar_exp = 8'hFF;
`endif
    cyc(1, 2'b01, 4'b0010, 8'hFF, 1, 0, 4'b1111);
    cyc(1, 2'b10, 4'b0010, 8'h00, 1, 0, 0);
    n_cmp++;
    if (out_a !== sp_exp || wrap_flag[1] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_sp_inc: got %h f1=%b, need %h f1=1", out_a, wrap_flag[1], sp_exp);
    end
    cyc(1, 2'b00, 4'b0001, 8'h00, 1, 0, 0);
    cyc(1, 2'b11, 4'b0001, 8'h00, 1, 0, 0);
    n_cmp++;
    if (out_b !== ar_exp || wrap_flag[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_ar_dec: got %h f0=%b, need %h f0=1", out_b, wrap_flag[0], ar_exp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL wrap_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_flag_priority();
    snap_t e, o;
    cyc(1, 2'b01, 4'b0010, 8'hFF, 1, 1, 4'b0010);
    cyc(1, 2'b10, 4'b0010, 8'h00, 1, 1, 4'b0010);
    n_cmp++;
    if (wrap_flag[1] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL flag_set_wins: got f1=%b, need 1", wrap_flag[1]);
    end
    cyc(0, 2'b10, 4'b0010, 8'h00, 1, 1, 4'b0010);
    n_cmp++;
    if (wrap_flag[1] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flag_clear_en0: got f1=%b, need 0", wrap_flag[1]);
    end
    cyc(1, 2'b01, 4'b1111, 8'h00, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL flag_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_hold();
    snap_t e, o;
    cyc(1, 2'b01, 4'b0001, 8'h11, 0, 0, 0);
    cyc(1, 2'b01, 4'b0010, 8'h22, 0, 0, 0);
    cyc(1, 2'b01, 4'b0100, 8'h33, 0, 0, 0);
    cyc(1, 2'b01, 4'b1000, 8'h44, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 2'b00, 4'b1111, 8'h00, S'(i), S'(3 - (i % 4)), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL hold_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    logic [W-1:0] d;
    for (int i = 0; i < 60; i++) begin
      d = ($urandom_range(0, 2) == 0) ? 8'hFF : (($urandom_range(0, 1) == 0) ? 8'h00 : W'($urandom));
      cyc(($urandom_range(0, 4) != 0), 2'($urandom), 4'($urandom), d, 2'($urandom), 2'($urandom),
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL b2b_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  task automatic test_param6();
    snap6_t e, o;
    logic [15:0] wrapped;
`ifdef ARF_SATURATE_EN
    wrapped = 16'hFFFF;
`else
    wrapped = 16'h0000;
`endif
    for (int step = 0; step < 4; step++) begin
      @(negedge clk);
      p_en = 1'b0; p_fun = 2'b00; p_rsel = 6'b100000; p_data = 16'h0000;
      p_asel = 3'd7; p_bsel = 3'd6; p_fclr = 6'b000000;
      case (step)
        0: exp6_q.push_back('{a: 16'h0000, b: 16'h0000, f: 6'b000000});
        1: begin
          p_en = 1'b1; p_fun = 2'b01; p_data = 16'hFFFF; p_asel = 3'd5;
          exp6_q.push_back('{a: 16'hFFFF, b: 16'h0000, f: 6'b000000});
        end
        2: begin
          p_en = 1'b1; p_fun = 2'b10; p_asel = 3'd5; p_bsel = 3'd5;
          exp6_q.push_back('{a: wrapped, b: wrapped, f: 6'b100000});
        end
        default: begin
          p_fclr = 6'b100000; p_asel = 3'd5;
          exp6_q.push_back('{a: wrapped, b: 16'h0000, f: 6'b000000});
        end
      endcase
      @(posedge clk);
      #1;
      obs6_q.push_back('{a: p_out_a, b: p_out_b, f: p_wrap});
    end
    while (exp6_q.size() > 0) begin
      e = exp6_q.pop_front();
      o = obs6_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL param6_seq: got a=%h b=%h f=%b, need a=%h b=%h f=%b", o.a, o.b, o.f, e.a, e.b, e.f);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; fun_sel = 2'b00; r_sel = '0; i_data = '0;
    a_sel = '0; b_sel = '0; flag_clr = '0;
    p_en = 1'b0; p_fun = 2'b00; p_rsel = '0; p_data = '0;
    p_asel = '0; p_bsel = '0; p_fclr = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_multi_select();
    test_wrap();
    test_flag_priority();
    test_hold();
    test_back_to_back();
    test_param6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
